// File: rtl/mdu_ctrl.sv
// mdu_ctrl: M-extension sequencer for the execute stage.
// Launches the external multiplier for MUL-class ops, runs an internal
// 32-step restoring divider for DIV-class ops, and returns one result
// over a valid/ready response port. busy stalls the pipeline while active.
module mdu_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_a_signed,
  output logic        mul_b_signed,
  input  logic [63:0] mul_product,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_RUN,
    S_DIV_FIX,
    S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [4:0]  cnt;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        q_neg;
  logic        r_neg;

  logic        req_is_mul;
  logic        req_signed_div;
  logic        req_is_rem;
  logic        b_zero;
  logic        sgn_ovf;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] special_data;
  logic [32:0] trial;
  logic [31:0] fix_data;

  // Request decode, divider step datapath and sign fix-up
  always_comb begin
    req_is_mul     = ~req_op[2];
    req_signed_div = req_op[2] & ~req_op[0];
    req_is_rem     = req_op[1];
    b_zero         = (req_b == '0);
    sgn_ovf        = req_signed_div && (req_a == 32'h8000_0000) && (req_b == '1);
    abs_a          = (req_signed_div && req_a[31]) ? -req_a : req_a;
    abs_b          = (req_signed_div && req_b[31]) ? -req_b : req_b;
    // Divide by zero is tested first so it wins over signed overflow
    if (b_zero) begin
      special_data = req_is_rem ? req_a : '1;
    end else begin
      special_data = req_is_rem ? '0 : 32'h8000_0000;
    end
    // Dividend bits are shifted out of quo_q's MSB as quotient bits enter at its LSB
    trial    = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    if (op_q[1]) begin
      fix_data = r_neg ? -rem_q : rem_q;
    end else begin
      fix_data = q_neg ? -quo_q : quo_q;
    end
  end

  // Main sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_q         <= '0;
      cnt          <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      mul_start    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_a_signed <= 1'b0;
      mul_b_signed <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_rd      <= '0;
    end else begin
      mul_start <= 1'b0;
      if (flush) begin
        state      <= S_IDLE;
        req_ready  <= 1'b1;
        busy       <= 1'b0;
        resp_valid <= 1'b0;
        cnt        <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid && req_ready) begin
              op_q      <= req_op;
              resp_rd   <= req_rd;
              req_ready <= 1'b0;
              busy      <= 1'b1;
              cnt       <= '0;
              if (req_is_mul) begin
                mul_a        <= req_a;
                mul_b        <= req_b;
                mul_a_signed <= (req_op == 3'd1) || (req_op == 3'd2);
                mul_b_signed <= (req_op == 3'd1);
                mul_start    <= 1'b1;
                state        <= S_MUL_WAIT;
              end else if (b_zero || sgn_ovf) begin
                resp_data  <= special_data;
                resp_valid <= 1'b1;
                state      <= S_DONE;
              end else begin
                rem_q <= '0;
                quo_q <= abs_a;
                dvs_q <= abs_b;
                q_neg <= req_signed_div & (req_a[31] ^ req_b[31]);
                r_neg <= req_signed_div & req_a[31];
                state <= S_DIV_RUN;
              end
            end
          end
          S_MUL_WAIT: begin
            if (cnt == 5'(MUL_LAT - 1)) begin
              resp_data  <= (op_q == 3'd0) ? mul_product[31:0] : mul_product[63:32];
              resp_valid <= 1'b1;
              cnt        <= '0;
              state      <= S_DONE;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          S_DIV_RUN: begin
            if (!trial[32]) begin
              rem_q <= trial[31:0];
              quo_q <= {quo_q[30:0], 1'b1};
            end else begin
              rem_q <= {rem_q[30:0], quo_q[31]};
              quo_q <= {quo_q[30:0], 1'b0};
            end
            if (cnt == 5'd31) begin
              cnt   <= '0;
              state <= S_DIV_FIX;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          S_DIV_FIX: begin
            resp_data  <= fix_data;
            resp_valid <= 1'b1;
            state      <= S_DONE;
          end
          S_DONE: begin
            if (resp_ready) begin
              resp_valid <= 1'b0;
              req_ready  <= 1'b1;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized self-checking bench for mdu_ctrl with a
// behavioural multiplier model and an arithmetic reference for results/latency.
module tb_mdu_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_a_signed;
  logic        mul_b_signed;
  logic [63:0] mul_product;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_a_signed(mul_a_signed), .mul_b_signed(mul_b_signed),
    .mul_product(mul_product),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: product is valid only in the cycle it is due, garbage otherwise
  logic [63:0] prod_q = '0;
  int unsigned age = 100;
  always @(posedge clk) begin
    if (mul_start) begin
      prod_q <= (mul_a_signed ? {{32{mul_a[31]}}, mul_a} : {32'b0, mul_a}) *
                (mul_b_signed ? {{32{mul_b[31]}}, mul_b} : {32'b0, mul_b});
      age    <= 1;
    end else if (age < 100) begin
      age <= age + 1;
    end
  end
  assign mul_product = (age == MUL_LAT - 1) ? prod_q : 64'hDEAD_BEEF_0BAD_F00D;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    ia = $signed(a); ib = $signed(b);
    p = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 4) return MUL_LAT + 1;
    if (b == 0) return 1;
    if ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Drive one request; returns at the negedge of cycle T+1 with req_valid dropped
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, output bit was_ready);
    @(negedge clk);
    was_ready = (req_ready === 1'b1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp;
    int exp_lat, k;
    bit rdy;
    logic exp_as, exp_bs;
    exp = ref_result(op, a, b);
    exp_lat = ref_lat(op, a, b);
    exp_as = (op == 1 || op == 2);
    exp_bs = (op == 1);
    resp_ready = 1'b1;
    send(op, a, b, rd, rdy);
    checks++;
    if (!rdy) begin failures++; $display("FAIL accept_ready op=%0d got req_ready=0 want 1", op); end
    checks++;
    if (mul_start !== (op < 4) || busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL first_cycle op=%0d mul_start=%b busy=%b req_ready=%b want %b/1/0", op, mul_start, busy, req_ready, op < 4);
    end
    if (op < 4) begin
      checks++;
      if (mul_a_signed !== exp_as || mul_b_signed !== exp_bs || mul_a !== a || mul_b !== b) begin
        failures++;
        $display("FAIL mul_operands op=%0d sign=%b/%b want %b/%b a=%h b=%h want %h %h",
                 op, mul_a_signed, mul_b_signed, exp_as, exp_bs, mul_a, mul_b, a, b);
      end
    end
    k = 1;
    while (resp_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != exp_lat || resp_data !== exp || resp_rd !== rd) begin
      failures++;
      $display("FAIL result op=%0d a=%h b=%h lat=%0d data=%h rd=%0d want lat=%0d data=%h rd=%0d",
               op, a, b, k, resp_data, resp_rd, exp_lat, exp, rd);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_handshake op=%0d ready=%b busy=%b valid=%b want 1/0/0", op, req_ready, busy, resp_valid);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'h0 ||
        resp_rd !== 5'h0 || mul_start !== 1'b0 || mul_a !== 32'h0 || mul_b !== 32'h0 ||
        mul_a_signed !== 1'b0 || mul_b_signed !== 1'b0) begin
      failures++;
      $display("FAIL %s rdy=%b busy=%b v=%b d=%h rd=%h ms=%b a=%h b=%h s=%b%b want reset values",
               name, req_ready, busy, resp_valid, resp_data, resp_rd, mul_start, mul_a, mul_b,
               mul_a_signed, mul_b_signed);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2);
    run_op(3'd5, 32'd5, 32'd0, 5'd3);
    run_op(3'd7, 32'd5, 32'd0, 5'd4);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    run_op(3'd4, 32'h8000_0000, 32'd0, 5'd8);
    run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11);
  endtask

  task automatic test_random;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom));
    end
  endtask

  task automatic test_flush;
    bit rdy;
    int seen;
    resp_ready = 1'b1;
    // Flush mid-divide at T+10
    send(3'd4, 32'd1000, 32'd7, 5'd12, rdy);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_div ready=%b busy=%b valid=%b want 1/0/0", req_ready, busy, resp_valid);
    end
    seen = 0;
    repeat (30) begin @(negedge clk); if (resp_valid === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL flush_no_resp got %0d valid cycles want 0", seen); end
    run_op(3'd0, 32'd3, 32'd4, 5'd21);
    // Request presented in the flush cycle is ignored
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd2; req_b = 32'd2; req_rd = 5'd3; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || mul_start !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_accept ready=%b busy=%b mul_start=%b want 1/0/0", req_ready, busy, mul_start);
    end
    // Flush during the multiply wait; the late product must not leak into the next op
    send(3'd3, 32'hFFFF_0000, 32'h0001_0000, 5'd4, rdy);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_mul ready=%b busy=%b valid=%b want 1/0/0", req_ready, busy, resp_valid);
    end
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5'd30);
  endtask

  task automatic test_backpressure;
    bit rdy;
    int k;
    logic [31:0] exp;
    exp = ref_result(3'd0, 32'hABCD_0123, 32'h0000_0F0F);
    resp_ready = 1'b0;
    send(3'd0, 32'hABCD_0123, 32'h0000_0F0F, 5'd17, rdy);
    k = 1;
    while (resp_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (k != MUL_LAT + 1 || resp_data !== exp) begin
      failures++;
      $display("FAIL bp_result lat=%0d data=%h want lat=%0d data=%h", k, resp_data, MUL_LAT + 1, exp);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp || resp_rd !== 5'd17 || busy !== 1'b1 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d v=%b d=%h rd=%0d busy=%b rdy=%b want 1/%h/17/1/0",
                 i, resp_valid, resp_data, resp_rd, busy, req_ready, exp);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release ready=%b busy=%b valid=%b want 1/0/0", req_ready, busy, resp_valid);
    end
  endtask

  task automatic test_mid_reset;
    bit rdy;
    resp_ready = 1'b1;
    send(3'd1, 32'h1357_9BDF, 32'h2468_ACE0, 5'd25, rdy);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    rst_n = 1'b1;
    run_op(3'd5, 32'd100, 32'd9, 5'd26);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = '0;
    req_a = '0; req_b = '0; req_rd = '0; resp_ready = 1'b1;
    test_reset();
    test_directed();
    test_flush();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the M-extension path of the execute stage. Accepts one MUL/DIV-class operation at a time over a valid/ready handshake. Multiplies run on the external multiplier, with a fixed-latency wait and product capture. Divides and remainders use an internal 32-step restoring divider with RISC-V corner-case handling. Returns a single result over a valid/ready response port. Drives a pipeline stall while busy and honours pipeline flush.

## Interface

Parameters:
- MUL_LAT, 2: cycles from `mul_start` to a valid `mul_product`; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- flush  in  1  discard any in-flight or pending operation.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_op  in  3  operation code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_a  in  32  rs1 operand.
- req_b  in  32  rs2 operand.
- req_rd  in  5  destination tag, returned unchanged.
- mul_start  out  1  one-cycle pulse launching the multiplier.
- mul_a  out  32  registered multiplier operand A.
- mul_b  out  32  registered multiplier operand B.
- mul_a_signed  out  1  treat A as signed.
- mul_b_signed  out  1  treat B as signed.
- mul_product  in  64  multiplier result; sampled MUL_LAT cycles after `mul_start`.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  32  result.
- resp_rd  out  5  destination tag of result.
- busy  out  1  high in every state except IDLE; used as execute-stage stall.

## Operation

States and transitions:
- IDLE: accept a request when req_valid, req_ready and no flush are all high.
  - MUL-class (op 0-3) -> MUL_WAIT.
  - DIV-class with special case -> DONE.
  - Other DIV-class -> DIV_RUN.
- MUL_WAIT: entered with `mul_start` pulsed in its first cycle; stays MUL_LAT cycles.
  - Last cycle captures `mul_product`: op 0 takes bits [31:0], ops 1-3 take bits [63:32].
  - Then -> DONE.
- DIV_RUN: 32 iterations on operand magnitudes, counter 0..31.
  - Each step: shift remainder left, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit.
  - Then -> DIV_FIX.
- DIV_FIX: apply signs for DIV/REM. Quotient is negated when operand signs differ; remainder takes the dividend sign. Then -> DONE.
- DONE: hold resp_valid, resp_data and resp_rd until resp_ready; -> IDLE on the handshake cycle.

Multiplier signedness: MUL 0/0, MULH 1/1, MULHSU 1/0, MULHU 0/0 (mul_a_signed / mul_b_signed).

Division special cases, result registered directly in DONE:
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = req_a.
- Signed overflow (req_a = 0x80000000, req_b = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- Divide by zero takes precedence over signed overflow.

Flush:
- Any state returns to IDLE on the next edge.
- resp_valid drops and mul_start is suppressed.
- A request presented in the flush cycle is not accepted.
- A late `mul_product` is ignored.

Reset values: state IDLE, req_ready 1 after reset, and 0 for resp_valid, resp_data, resp_rd, busy, mul_start, mul_a, mul_b, mul_a_signed, mul_b_signed, and the iteration counter.

## Timing

- Accept edge = cycle T.
- MUL-class: mul_start high in T+1; product sampled at the end of T+MUL_LAT; resp_valid from T+MUL_LAT+1 (default T+3).
- DIV normal: DIV_RUN T+1..T+32, DIV_FIX T+33, resp_valid from T+34.
- DIV special case: resp_valid from T+1.
- resp_ready low stretches DONE indefinitely; outputs stay stable.
- After the response handshake in cycle D, req_ready is high in D+1. There are no back-to-back accepts in the DONE cycle.
- busy is high from T+1 through the response-handshake cycle inclusive.
- A synchronous reset mid-operation behaves like flush, and all outputs also take their reset values.

## Test plan

- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF, model multiplier MUL_LAT=2 -> mul_start at T+1 with signed flags 0/0; resp_data 0xFFFFFFFE at T+3.
- DIV a=0xFFFFFFF9 (-7), b=2 -> resp_data 0xFFFFFFFD at T+34. REM with the same operands -> 0xFFFFFFFF.
- DIVU a=5, b=0 -> resp_data 0xFFFFFFFF at T+1. REMU a=5, b=0 -> 5.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at T+1. REM with the same operands -> 0.
- Start DIV, assert flush at T+10 -> IDLE and req_ready high at T+11; no resp_valid. The next MUL 3×4 returns 12 with the correct resp_rd.
- MUL response held with resp_ready low for 5 cycles -> resp_data and resp_rd stable, busy high, req_ready low. Releasing resp_ready -> IDLE next cycle.
